// File: rtl/fp_ex_issue_ctrl.sv
// Sequencing controller for the clocked FP ALU in the EX stage.
// Accepts one op at a time from ID/EX, selects its latency from the FALU opcode,
// drives the ALU opcode/start, counts EXEC cycles and captures the ALU result
// into an EX/MEM-side output register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   flush                           synchronous kill of in-flight/held op
//   in_valid/in_ready               ID/EX handshake
//   in_falu_opcode, in_rd_addr,
//   in_move_en, in_cvt_en,
//   in_wb_fp_en, in_wb_int_en       op fields presented with in_valid
//   alu_opcode, alu_start           FP ALU controls
//   alu_result                      FP ALU output, sampled at end of last EXEC cycle
//   out_valid/out_ready             EX/MEM handshake
//   out_result, out_rd,
//   out_wb_fp_en, out_wb_int_en     captured result and carried control
//   stall_id                        hold ID/EX (in_valid & ~in_ready)
//   busy                            controller not idle
module fp_ex_issue_ctrl #(
  parameter logic [4:0]  OPC_MUL  = 5'd2,
  parameter logic [4:0]  OPC_DIV  = 5'd3,
  parameter logic [4:0]  OPC_SQRT = 5'd4,
  parameter int unsigned LAT_DEF  = 1,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_falu_opcode,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_move_en,
  input  logic        in_cvt_en,
  input  logic        in_wb_fp_en,
  input  logic        in_wb_int_en,
  output logic [4:0]  alu_opcode,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wb_fp_en,
  output logic        out_wb_int_en,
  output logic        stall_id,
  output logic        busy
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_q;
  logic               wb_fp_q, wb_int_q;
  logic               accept;
  logic               capture;

  // Latency minus one for the offered op; a zero latency behaves as one.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [4:0] op,
                                               input logic       mv,
                                               input logic       cvt);
    int unsigned l;
    if (mv || cvt)          l = LAT_DEF;
    else if (op == OPC_SQRT) l = LAT_SQRT;
    else if (op == OPC_DIV)  l = LAT_DIV;
    else if (op == OPC_MUL)  l = LAT_MUL;
    else                     l = LAT_DEF;
    if (l == 0) l = 1;
    return CNT_W'(l - 1);
  endfunction

  // Next-state, handshake and counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    capture  = 1'b0;

    case (state_q)
      IDLE:    in_ready = 1'b1;
      EXEC:    in_ready = 1'b0;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;

    accept = in_valid && in_ready;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = EXEC;
            cnt_d   = lat_m1(in_falu_opcode, in_move_en, in_cvt_en);
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = DONE;
            capture = 1'b1;
          end
        end
        DONE: begin
          // Handshake with a simultaneous accept goes straight back to EXEC.
          if (out_ready) begin
            if (accept) begin
              state_d = EXEC;
              cnt_d   = lat_m1(in_falu_opcode, in_move_en, in_cvt_en);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall_id = in_valid & ~in_ready;
  assign busy     = (state_q != IDLE);

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_q          <= '0;
      wb_fp_q       <= 1'b0;
      wb_int_q      <= 1'b0;
      alu_opcode    <= '0;
      alu_start     <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_wb_fp_en  <= 1'b0;
      out_wb_int_en <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_start <= accept;
      out_valid <= (state_d == DONE);
      if (accept) begin
        alu_opcode <= in_falu_opcode;
        rd_q       <= in_rd_addr;
        wb_fp_q    <= in_wb_fp_en;
        wb_int_q   <= in_wb_int_en;
      end
      if (capture) begin
        out_result    <= alu_result;
        out_rd        <= rd_q;
        out_wb_fp_en  <= wb_fp_q;
        out_wb_int_en <= wb_int_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_ex_issue_ctrl.sv
// Directed self-checking bench for fp_ex_issue_ctrl.
module tb_fp_ex_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_falu_opcode;
  logic [4:0]  in_rd_addr;
  logic        in_move_en;
  logic        in_cvt_en;
  logic        in_wb_fp_en;
  logic        in_wb_int_en;
  logic [4:0]  alu_opcode;
  logic        alu_start;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_fp_en;
  logic        out_wb_int_en;
  logic        stall_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fp_ex_issue_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_falu_opcode (in_falu_opcode),
    .in_rd_addr     (in_rd_addr),
    .in_move_en     (in_move_en),
    .in_cvt_en      (in_cvt_en),
    .in_wb_fp_en    (in_wb_fp_en),
    .in_wb_int_en   (in_wb_int_en),
    .alu_opcode     (alu_opcode),
    .alu_start      (alu_start),
    .alu_result     (alu_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wb_fp_en   (out_wb_fp_en),
    .out_wb_int_en  (out_wb_int_en),
    .stall_id       (stall_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] op, input logic [4:0] rd,
                       input logic mv, input logic cvt);
    in_valid       = 1'b1;
    in_falu_opcode = op;
    in_rd_addr     = rd;
    in_move_en     = mv;
    in_cvt_en      = cvt;
  endtask

  int n;
  int starts;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_falu_opcode = '0;
    in_rd_addr = '0; in_move_en = 1'b0; in_cvt_en = 1'b0; in_wb_fp_en = 1'b0;
    in_wb_int_en = 1'b0; alu_result = '0; out_ready = 1'b0;
    step(); step();

    // Reset state
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_alu_op",    32'(alu_opcode), 32'd0);
    check("rst_start",     32'(alu_start),  32'd0);
    rst_n = 1'b1;
    step();

    // Add, latency 1, followed by 5 cycles of backpressure
    offer(5'd0, 5'd5, 1'b0, 1'b0);
    in_wb_fp_en = 1'b1; in_wb_int_en = 1'b0;
    alu_result = 32'h4040_0000;
    step();                                        // accept edge 0
    in_valid = 1'b0; in_wb_fp_en = 1'b0;
    check("add_start", 32'(alu_start), 32'd1);
    check("add_busy",  32'(busy),      32'd1);
    check("add_exec_ready", 32'(in_ready), 32'd0);
    step();                                        // edge 1
    alu_result = 32'hdead_beef;
    check("add_valid",  32'(out_valid),    32'd1);
    check("add_result", out_result,        32'h4040_0000);
    check("add_rd",     32'(out_rd),       32'd5);
    check("add_wbfp",   32'(out_wb_fp_en), 32'd1);
    check("add_wbint",  32'(out_wb_int_en),32'd0);
    check("add_start_off", 32'(alu_start), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid",  32'(out_valid), 32'd1);
      check("bp_result", out_result,     32'h4040_0000);
      check("bp_rd",     32'(out_rd),    32'd5);
      check("bp_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_busy",  32'(busy),      32'd0);
    out_ready = 1'b0;

    // Div, latency 12, ID/EX holds its next op meanwhile
    offer(5'd3, 5'd7, 1'b0, 1'b0);
    alu_result = 32'h3f80_0000;
    step();                                        // accept edge
    starts = alu_start ? 1 : 0;
    check("div_stall", 32'(stall_id), 32'd1);
    check("div_alu_op", 32'(alu_opcode), 32'd3);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
      if (alu_start) starts++;
    end
    check("div_latency", 32'(n), 32'd12);
    check("div_starts",  32'(starts), 32'd1);
    check("div_result",  out_result, 32'h3f80_0000);
    check("div_rd",      32'(out_rd), 32'd7);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("div_idle", 32'(busy), 32'd0);

    // Back-to-back: mul then add
    offer(5'd2, 5'd3, 1'b0, 1'b0);
    alu_result = 32'h1111_1111;
    step();                                        // mul accept
    in_valid = 1'b0;
    check("mul_alu_op", 32'(alu_opcode), 32'd2);
    step(); step();
    check("mul_not_yet", 32'(out_valid), 32'd0);
    step();                                        // edge 3
    check("mul_valid",  32'(out_valid), 32'd1);
    check("mul_result", out_result,     32'h1111_1111);
    offer(5'd0, 5'd4, 1'b0, 1'b0);
    alu_result = 32'h2222_2222;
    #1;
    check("b2b_ready", 32'(in_ready), 32'd1);
    step();                                        // handshake + accept
    in_valid = 1'b0;
    check("b2b_valid_drop", 32'(out_valid), 32'd0);
    check("b2b_busy",       32'(busy),      32'd1);
    check("b2b_start",      32'(alu_start), 32'd1);
    check("b2b_alu_op",     32'(alu_opcode),32'd0);
    step();
    check("b2b_add_valid",  32'(out_valid), 32'd1);
    check("b2b_add_result", out_result,     32'h2222_2222);
    check("b2b_add_rd",     32'(out_rd),    32'd4);
    step();
    check("b2b_idle", 32'(busy), 32'd0);

    // Move/convert override the long latencies
    offer(5'd4, 5'd9, 1'b1, 1'b0);
    alu_result = 32'h0000_0abc;
    step(); in_valid = 1'b0;
    step();
    check("move_lat1", 32'(out_valid), 32'd1);
    check("move_result", out_result, 32'h0000_0abc);
    step();
    offer(5'd3, 5'd10, 1'b0, 1'b1);
    step(); in_valid = 1'b0;
    step();
    check("cvt_lat1", 32'(out_valid), 32'd1);
    step();

    // Flush during sqrt EXEC with cnt=7; a move offered then is refused
    out_ready = 1'b0;
    offer(5'd4, 5'd11, 1'b0, 1'b0);
    step();                                        // cnt=15
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();            // cnt=7
    check("sqrt_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    offer(5'd0, 5'd12, 1'b1, 1'b0);
    #1;
    check("flush_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; in_move_en = 1'b0;
    check("flush_busy",  32'(busy),      32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_start", 32'(alu_start), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("flush_no_result", 32'(out_valid), 32'd0);

    // Reset asserted mid-EXEC of a div
    offer(5'd3, 5'd13, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready),  32'd1);
    check("rst_mid_start", 32'(alu_start), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("rst_mid_no_result", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
